// File: rtl/exp_align_unit.sv
// Exponent alignment for floating-point add: selects the larger exponent and
// right-shifts the smaller mantissa one bit per clock, keeping guard/round/sticky.
module exp_align_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  reg1,
    input  logic [7:0]  reg2,
    input  logic [7:0]  diff,
    input  logic        cout,
    input  logic [23:0] man_a,
    input  logic [23:0] man_b,
    output logic [7:0]  exp_out,
    output logic [23:0] man_big,
    output logic [26:0] man_small,
    output logic        swap,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [7:0]  r_exp;
    logic [23:0] r_man_big;
    logic [26:0] r_man_small;
    logic        r_swap;

    logic [7:0]  w_n;
    logic [23:0] w_small;
    logic [26:0] w_shifted;

    // On a borrow the subtractor result is negative; negate it to get the distance.
    assign w_n       = cout ? diff : (~diff + 8'd1);
    assign w_small   = cout ? man_b : man_a;
    // Bits falling off the bottom are folded into sticky so it can never clear.
    assign w_shifted = {1'b0, r_man_small[26:2], r_man_small[1] | r_man_small[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= 5'd0;
            r_exp       <= 8'd0;
            r_man_big   <= 24'd0;
            r_man_small <= 27'd0;
            r_swap      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_exp     <= cout ? reg1 : reg2;
                        r_man_big <= cout ? man_a : man_b;
                        r_swap    <= ~cout;
                        if (w_n == 8'd0) begin
                            r_man_small <= {w_small, 3'b000};
                            r_state     <= S_DONE;
                        end else if (w_n <= 8'd26) begin
                            r_man_small <= {w_small, 3'b000};
                            r_count     <= w_n[4:0];
                            r_state     <= S_SHIFT;
                        end else begin
                            // Everything shifts out: only the sticky summary survives.
                            r_man_small <= {26'd0, |w_small};
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_man_small <= w_shifted;
                    r_count     <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign exp_out   = r_exp;
    assign man_big   = r_man_big;
    assign man_small = r_man_small;
    assign swap      = r_swap;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_exp_align_unit.sv
// Directed bench for exp_align_unit: hand-computed alignment results and latencies.
module tb_exp_align_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  reg1;
    logic [7:0]  reg2;
    logic [7:0]  diff;
    logic        cout;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [7:0]  exp_out;
    logic [23:0] man_big;
    logic [26:0] man_small;
    logic        swap;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;
    int edges;

    exp_align_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg1      (reg1),
        .reg2      (reg2),
        .diff      (diff),
        .cout      (cout),
        .man_a     (man_a),
        .man_b     (man_b),
        .exp_out   (exp_out),
        .man_big   (man_big),
        .man_small (man_small),
        .swap      (swap),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] d,
                           input logic c, input logic [23:0] ma, input logic [23:0] mb);
        reg1  = r1;
        reg2  = r2;
        diff  = d;
        cout  = c;
        man_a = ma;
        man_b = mb;
    endtask

    // Pulses start across one edge (E0); returns 1ns after E0.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts further edges until done is seen, bounded so a stuck design still finishes.
    task automatic wait_done(inout int cnt);
        while (done !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [7:0] e_exp, input logic [23:0] e_big,
                                input logic [26:0] e_small, input logic e_swap);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_exp"}, {24'd0, exp_out}, {24'd0, e_exp});
        chk({tag, "_big"}, {8'd0, man_big}, {8'd0, e_big});
        chk({tag, "_small"}, {5'd0, man_small}, {5'd0, e_small});
        chk({tag, "_swap"}, {31'd0, swap}, {31'd0, e_swap});
        $display("txn %s: latency=%0d exp=%h big=%h small=%h swap=%b",
                 tag, lat, exp_out, man_big, man_small, swap);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_ops(8'h00, 8'h00, 8'h00, 1'b0, 24'h0, 24'h0);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_small", {5'd0, man_small}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // n=3, sticky collects the low 1 of man_b
        set_ops(8'h85, 8'h82, 8'h03, 1'b1, 24'h123456, 24'h800001);
        do_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        edges = 0;
        wait_done(edges);
        check_result("t1", edges, 3, 8'h85, 24'h123456, 27'h0800001, 1'b0);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_hold_small", {5'd0, man_small}, 32'h0800001);

        // borrow case: n = -(0xFE) = 2, B is larger
        set_ops(8'h7F, 8'h81, 8'hFE, 1'b0, 24'hC00000, 24'hABCDEF);
        do_start();
        edges = 0;
        wait_done(edges);
        check_result("t2", edges, 2, 8'h81, 24'hABCDEF, 27'h1800000, 1'b1);
        // start presented during the DONE cycle must be ignored
        set_ops(8'h40, 8'h10, 8'h30, 1'b1, 24'h111111, 24'h222222);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_start_in_done_busy", {31'd0, busy}, 32'd0);
        chk("t2_start_in_done_exp", {24'd0, exp_out}, 32'h81);
        tick();
        chk("t2_still_idle", {31'd0, busy}, 32'd0);

        // n=0: done right after the start edge
        set_ops(8'h90, 8'h90, 8'h00, 1'b1, 24'h900000, 24'hF0F0F0);
        do_start();
        edges = 0;
        wait_done(edges);
        check_result("t3", edges, 0, 8'h90, 24'h900000, 27'h7878780, 1'b0);
        tick();

        // n=40: everything shifted out, sticky only
        set_ops(8'hA8, 8'h80, 8'h28, 1'b1, 24'hFFFFFF, 24'h800000);
        do_start();
        edges = 0;
        wait_done(edges);
        check_result("t4", edges, 0, 8'hA8, 24'hFFFFFF, 27'h0000001, 1'b0);
        tick();

        // n=26: largest shift done step by step
        set_ops(8'h9A, 8'h80, 8'h1A, 1'b1, 24'h000001, 24'h800000);
        do_start();
        edges = 0;
        wait_done(edges);
        check_result("t5", edges, 26, 8'h9A, 24'h000001, 27'h0000001, 1'b0);
        tick();

        // n=27 with a zero mantissa: sticky stays clear
        set_ops(8'h9B, 8'h80, 8'h1B, 1'b1, 24'h00ABCD, 24'h000000);
        do_start();
        edges = 0;
        wait_done(edges);
        check_result("t6", edges, 0, 8'h9B, 24'h00ABCD, 27'h0000000, 1'b0);
        tick();

        // n=10 with a second start during SHIFT
        set_ops(8'h8A, 8'h80, 8'h0A, 1'b1, 24'h111111, 24'hFFFFFF);
        do_start();
        edges = 0;
        tick(); tick(); tick();
        edges = 3;
        set_ops(8'h10, 8'hEE, 8'h01, 1'b0, 24'h555555, 24'h666666);
        start = 1'b1;
        tick();
        edges++;
        start = 1'b0;
        wait_done(edges);
        check_result("t7", edges, 10, 8'h8A, 24'h111111, 27'h001FFFF, 1'b0);
        tick();
        chk("t7_no_requeue_done", {31'd0, done}, 32'd0);
        chk("t7_no_requeue_busy", {31'd0, busy}, 32'd0);

        // reset during the 4th SHIFT cycle of n=10
        set_ops(8'h8A, 8'h80, 8'h0A, 1'b1, 24'h111111, 24'hFFFFFF);
        do_start();
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t8_rst_busy", {31'd0, busy}, 32'd0);
        chk("t8_rst_done", {31'd0, done}, 32'd0);
        chk("t8_rst_exp", {24'd0, exp_out}, 32'd0);
        chk("t8_rst_big", {8'd0, man_big}, 32'd0);
        chk("t8_rst_small", {5'd0, man_small}, 32'd0);
        chk("t8_rst_swap", {31'd0, swap}, 32'd0);
        $display("txn t8: reset asserted mid-shift, busy=%b done=%b", busy, done);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t8_no_done_after_rst", {31'd0, done}, 32'd0);

        // n=1 after reset
        set_ops(8'h81, 8'h80, 8'h01, 1'b1, 24'h0F0F0F, 24'h800003);
        do_start();
        edges = 0;
        wait_done(edges);
        check_result("t9", edges, 1, 8'h81, 24'h0F0F0F, 27'h200000C, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exp_align_unit.md
EXP_ALIGN_UNIT -- requirements
Module: exp_align_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all other state SHALL change only on rising clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to align one operand pair; sampled only in IDLE.
REQ-005 reg1  input  8  biased exponent of operand A.
REQ-006 reg2  input  8  biased exponent of operand B.
REQ-007 diff  input  8  reg1 - reg2 from the 8-bit subtractor stage, two's complement, modulo 256.
REQ-008 cout  input  1  subtractor carry-out: 1 = reg1 >= reg2, 0 = borrow (reg1 < reg2).
REQ-009 man_a  input  24  mantissa A, hidden bit included.
REQ-010 man_b  input  24  mantissa B, hidden bit included.
REQ-011 exp_out  output  8  larger exponent.
REQ-012 man_big  output  24  mantissa belonging to the larger exponent.
REQ-013 man_small  output  27  aligned smaller mantissa as {mantissa[23:0], guard, round, sticky}.
REQ-014 swap  output  1  1 when operand B had the larger exponent.
REQ-015 busy  output  1  high in LOAD-accepted SHIFT and DONE states.
REQ-016 done  output  1  one-cycle pulse; outputs valid while high and held afterwards.

Function
REQ-017 States SHALL be IDLE, SHIFT, DONE; after reset the state SHALL be IDLE.
REQ-018 In IDLE with start=1, the block SHALL register operands on that edge: cout=1 -> exp_out=reg1, man_big=man_a, small=man_b, swap=0; cout=0 -> exp_out=reg2, man_big=man_b, small=man_a, swap=1.
REQ-019 Shift amount n SHALL be diff when cout=1, else (~diff + 1) modulo 256; diff=0 with cout=1 gives n=0.
REQ-020 On load, man_small SHALL be {small, 3'b000}.
REQ-021 If n=0 the next state SHALL be DONE; if 1 <= n <= 26 the next state SHALL be SHIFT with counter=n.
REQ-022 If n >= 27 the block SHALL load man_small = {26'b0, |small} and go directly to DONE.
REQ-023 Each SHIFT edge SHALL apply man_small <= {1'b0, man_small[26:2], man_small[1] | man_small[0]} and decrement the counter.
REQ-024 The transition SHALL go to DONE on the edge where the counter reaches 0.
REQ-025 done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-026 Latency: with start sampled at edge E0, done SHALL be high after edge E0+min(n,26)-(n>=27 ? 26 : 0); i.e. n edges for n <= 26 and after E0 for n=0 or n >= 27.
REQ-027 start asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-028 start asserted in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-029 exp_out, man_big, man_small and swap SHALL hold their last values in IDLE until the next accepted start.
REQ-030 Sticky SHALL never clear during a shift sequence once set.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE and all outputs to 0, including when asserted mid-SHIFT.
REQ-032 After rst deasserts, the first accepted start SHALL behave identically to a start after power-up.

Verification
REQ-033 reg1=0x85, reg2=0x82, diff=0x03, cout=1, man_b=0x800001 -> done 3 edges after start, exp_out=0x85, swap=0, man_small={0x100000, G=0, R=0, S=1}.
REQ-034 reg1=0x7F, reg2=0x81, diff=0xFE, cout=0, man_a=0xC00000 -> n=2, exp_out=0x81, swap=1, man_big=man_b, man_small={0x300000, 3'b000}, done after 2 edges.
REQ-035 diff=0x00, cout=1 -> done after the start edge, man_small={man_b, 3'b000}, swap=0.
REQ-036 diff=0x28, cout=1, man_b=0x800000 -> n=40, done after the start edge, man_small=27'h0000001.
REQ-037 start pulsed again during SHIFT for n=10 -> ignored, one done pulse after 10 edges, outputs unchanged by the second start.
REQ-038 rst asserted on the 4th SHIFT cycle of n=10 -> outputs 0 and busy=0 immediately; no done pulse; a following start with n=1 completes in 1 edge.
